hamming32t26d_scrubber: RTL and testbench
=========================================

# hamming32t26d_scrubber

- Background memory scrubber for memories that hold Hamming (32,26) SEC-DED codewords.
- It walks every address, reads each codeword and checks its syndrome.
- A corrected codeword is written back on a single-bit error. A double-bit error is counted and flagged, and nothing is written.
- It sits beside the functional memory port behind an arbiter, as the checking/reading counterpart to the codeword writer.

## Interface
Parameters:
- DEPTH, 256, number of codeword entries (≥2)
- AW, $clog2(DEPTH), address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: one clock; reset is asynchronous and active-high
- en_i  in  1  scrubbing enable (level)
- interval_i  in  16  idle cycles inserted before each word's read
- clr_cnt_i  in  1  synchronous clear of sec/ded counters
- req_o  out  1  memory access request
- gnt_i  in  1  arbiter grant, qualifies req_o in the same cycle
- we_o  out  1  1 = write, 0 = read (valid with req_o)
- addr_o  out  AW  access address
- wdata_o  out  32  corrected codeword for write-back
- rdata_i  in  32  read codeword, valid the cycle after a granted read
- lock_o  out  1  held from granted read through completed write-back
- sec_cnt_o  out  16  corrected-error count, saturating
- ded_cnt_o  out  16  uncorrectable-error count, saturating
- ded_o  out  1  one-cycle pulse on double error
- ded_addr_o  out  AW  address of most recent double error
- pass_done_o  out  1  one-cycle pulse after the last address is checked
- busy_o  out  1  FSM not in IDLE

## Operation
Codeword layout:
- hv[0] is overall parity.
- hv[1], hv[2], hv[4], hv[8] and hv[16] are check bits.
- Data bits occupy the remaining positions, ordered MSB-first as {hv[31:17], hv[15:9], hv[7:5], hv[3]}.

Check logic:
- Syndrome s[4:0] = XOR of the indices i in 1..31 where hv[i]=1.
- p = ^hv[31:0].
- s=0, p=0: clean. No write.
- p=1: single error at bit s (s=0 means hv[0]). Write back hv ^ (1<<s) and increment sec_cnt.
- s≠0, p=0: double error. No write. Increment ded_cnt, pulse ded_o, load ded_addr_o.

FSM states:
- IDLE: leaves when en_i=1.
- WAIT: counts interval_i cycles. Skipped when interval_i=0.
- RD_REQ: req_o=1, we_o=0. Holds until gnt_i.
- RD_DATA: registers rdata_i.
- CHECK: evaluates the syndrome. Goes to WR_REQ on a single error, otherwise advances.
- WR_REQ: req_o=1, we_o=1. Holds until gnt_i.

Advance rules:
- Address increments after CHECK (no write) or after a granted write.
- DEPTH-1 wraps to 0 and pulses pass_done_o in the same cycle.
- After advancing, the FSM goes to WAIT/RD_REQ if en_i=1, else IDLE.

Boundary conditions:
- en_i falling mid-word: the current word completes, including a pending write-back. The address is retained and the next enable resumes at it.
- clr_cnt_i in the same cycle as an increment: clear wins and the counter reads 0.
- Counters saturate at 16'hFFFF.
- Reset asserted mid-operation: immediate return to IDLE. Address goes to 0 and all outputs take their reset values. Any half-done write is abandoned.

## Timing
- Reset value of every output is 0, including addr_o, wdata_o, the counters and ded_addr_o.
- While waiting for gnt_i, req_o, we_o, addr_o and wdata_o stay stable.
- Clean word with gnt_i=1 and interval_i=0: 3 cycles (RD_REQ, RD_DATA, CHECK). A single-error word takes 4.
- Counter, ded_o and ded_addr_o updates are visible the cycle after CHECK.
- pass_done_o is visible the cycle after the final advance.
- lock_o rises the cycle after the read grant and falls the cycle after CHECK (no write) or after the write grant.

## Structure
- hamming32t26d_pkg holds:
  - HV_WIDTH=32 and DATA_WIDTH=26;
  - the check-bit position constants;
  - the scrubber state enum type.
- Sub-module hamming32t26d_chk is combinational. Input hv. Outputs syndrome, sec, ded and corrected hv.
- The FSM, counters and address logic live in the top module.

## Test plan
All scenarios use DEPTH=8, gnt_i=1 and interval_i=0 unless stated.
- All words 32'h0, en_i=1 for 24 cycles:
  - 8 reads, no writes;
  - both counters 0;
  - one pass_done_o pulse;
  - addr_o returns to 0.
- Word 3 = 32'h0000_0007 (32'h0F with hv[3] flipped): write to addr 3 with wdata_o=32'h0000_000F; sec_cnt_o=1.
- Word 5 = 32'h0000_003F (32'h0F with hv[4] and hv[5] flipped):
  - no write;
  - ded_cnt_o=1;
  - ded_o pulses once;
  - ded_addr_o=5.
- Word 2 = 32'h0000_000E (hv[0] flipped): write-back of 32'h0000_000F; sec_cnt_o=1.
- Word 1 single error with gnt_i held low 10 cycles in WR_REQ and en_i dropped during the stall:
  - req_o, we_o, addr_o=1 and wdata_o stay stable;
  - the write completes on grant;
  - the FSM then goes to IDLE with the address at 2.
- Combined counter, interval and reset checks:
  - Preload sec_cnt to 16'hFFFF: a further error keeps it at 16'hFFFF.
  - clr_cnt_i in the same cycle as an increment: counter reads 0.
  - rst_i pulsed mid-RD_DATA: all outputs 0 and busy_o=0 at once.
  - interval_i=4: exactly 4 idle cycles between consecutive RD_REQ grants.

Source files
------------

// File: rtl/hamming32t26d_pkg.sv
// Shared constants and types for the Hamming (32,26) SEC-DED scrubber.
// Codeword: hv[0] overall parity, check bits at power-of-two positions.
package hamming32t26d_pkg;

  localparam int HV_WIDTH   = 32;
  localparam int DATA_WIDTH = 26;
  localparam int N_CHK      = HV_WIDTH - DATA_WIDTH - 1;
  localparam int CNT_WIDTH  = 16;

  localparam int PAR_POS            = 0;
  localparam int CHK_POS [N_CHK]    = '{1, 2, 4, 8, 16};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_CHECK   = 3'd4,
    ST_WR_REQ  = 3'd5
  } scrub_state_e;

endpackage

// File: rtl/hamming32t26d_chk.sv
// Combinational syndrome / parity evaluation and single-bit correction
// for one Hamming (32,26) SEC-DED codeword.
module hamming32t26d_chk
  import hamming32t26d_pkg::*;
(
  input  logic [HV_WIDTH-1:0] hv_i,
  output logic [N_CHK-1:0]    syn_o,
  output logic                sec_o,
  output logic                ded_o,
  output logic [HV_WIDTH-1:0] corr_o
);

  logic par;

  // Syndrome bit b is the parity of every position whose index has bit b set,
  // which equals bit b of the XOR of all set indices.
  always_comb begin
    syn_o = '0;
    for (int b = 0; b < N_CHK; b++) begin
      for (int i = 1; i < HV_WIDTH; i++) begin
        if ((i & CHK_POS[b]) != 0) syn_o[b] = syn_o[b] ^ hv_i[i];
      end
    end
    par    = ^hv_i;
    corr_o = hv_i;
    if (par) corr_o[syn_o] = ~hv_i[syn_o];
    if (par && syn_o == '0) corr_o[PAR_POS] = ~hv_i[PAR_POS];
  end

  assign sec_o = par;
  assign ded_o = ~par & (syn_o != '0);

endmodule

// File: rtl/hamming32t26d_scrubber.sv
// Background scrubber: walks all addresses, reads each codeword, writes back
// single-bit corrections and counts/flags uncorrectable double errors.
module hamming32t26d_scrubber
  import hamming32t26d_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [15:0]          interval_i,
  input  logic                 clr_cnt_i,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic                 we_o,
  output logic [AW-1:0]        addr_o,
  output logic [HV_WIDTH-1:0]  wdata_o,
  input  logic [HV_WIDTH-1:0]  rdata_i,
  output logic                 lock_o,
  output logic [CNT_WIDTH-1:0] sec_cnt_o,
  output logic [CNT_WIDTH-1:0] ded_cnt_o,
  output logic                 ded_o,
  output logic [AW-1:0]        ded_addr_o,
  output logic                 pass_done_o,
  output logic                 busy_o
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  scrub_state_e          state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [15:0]           wait_q, wait_d;
  logic [HV_WIDTH-1:0]   hv_q, hv_d;
  logic [HV_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_WIDTH-1:0]  ded_cnt_q, ded_cnt_d;
  logic                  ded_q, ded_d;
  logic [AW-1:0]         ded_addr_q, ded_addr_d;
  logic                  pass_done_q, pass_done_d;

  logic                  advance;
  logic                  start;
  logic [N_CHK-1:0]      chk_syn;
  logic                  chk_sec;
  logic                  chk_ded;
  logic [HV_WIDTH-1:0]   chk_corr;
  logic                  unused_syn;

  hamming32t26d_chk u_chk (
    .hv_i   (hv_q),
    .syn_o  (chk_syn),
    .sec_o  (chk_sec),
    .ded_o  (chk_ded),
    .corr_o (chk_corr)
  );

  assign unused_syn = ^chk_syn;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    hv_d        = hv_q;
    wdata_d     = wdata_q;
    sec_cnt_d   = sec_cnt_q;
    ded_cnt_d   = ded_cnt_q;
    ded_addr_d  = ded_addr_q;
    ded_d       = 1'b0;
    pass_done_d = 1'b0;
    advance     = 1'b0;
    start       = 1'b0;

    case (state_q)
      ST_IDLE:    start = en_i;
      ST_WAIT: begin
        if (wait_q == '0) state_d = ST_RD_REQ;
        else              wait_d  = wait_q - 16'd1;
      end
      ST_RD_REQ:  if (gnt_i) state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        hv_d    = rdata_i;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (chk_sec) begin
          wdata_d = chk_corr;
          if (sec_cnt_q != CNT_MAX) sec_cnt_d = sec_cnt_q + 16'd1;
          state_d = ST_WR_REQ;
        end else begin
          if (chk_ded) begin
            if (ded_cnt_q != CNT_MAX) ded_cnt_d = ded_cnt_q + 16'd1;
            ded_d      = 1'b1;
            ded_addr_d = addr_q;
          end
          advance = 1'b1;
        end
      end
      ST_WR_REQ:  advance = gnt_i;
      default:    state_d = ST_IDLE;
    endcase

    // Enable is only sampled between words, so a dropped enable lets the
    // current word (and any write-back) finish and keeps the address.
    if (advance) begin
      addr_d      = (addr_q == ADDR_LAST) ? '0 : addr_q + AW'(1);
      pass_done_d = (addr_q == ADDR_LAST);
      state_d     = ST_IDLE;
      start       = en_i;
    end

    if (start) begin
      if (interval_i == '0) begin
        state_d = ST_RD_REQ;
      end else begin
        state_d = ST_WAIT;
        wait_d  = interval_i - 16'd1;
      end
    end

    if (clr_cnt_i) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wait_q      <= '0;
      hv_q        <= '0;
      wdata_q     <= '0;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
      ded_q       <= 1'b0;
      ded_addr_q  <= '0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      hv_q        <= hv_d;
      wdata_q     <= wdata_d;
      sec_cnt_q   <= sec_cnt_d;
      ded_cnt_q   <= ded_cnt_d;
      ded_q       <= ded_d;
      ded_addr_q  <= ded_addr_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign req_o       = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign we_o        = (state_q == ST_WR_REQ);
  assign lock_o      = (state_q == ST_RD_DATA) || (state_q == ST_CHECK) ||
                       (state_q == ST_WR_REQ);
  assign busy_o      = (state_q != ST_IDLE);
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign sec_cnt_o   = sec_cnt_q;
  assign ded_cnt_o   = ded_cnt_q;
  assign ded_o       = ded_q;
  assign ded_addr_o  = ded_addr_q;
  assign pass_done_o = pass_done_q;

endmodule

// File: tb/tb_hamming32t26d_scrubber.sv
// Self-checking bench for hamming32t26d_scrubber (DEPTH=8) with a simple
// one-cycle-latency memory model and an encoder-based random reference.
module tb_hamming32t26d_scrubber;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic [15:0]   interval_i = 16'd0;
  logic          clr_cnt_i = 1'b0;
  logic          req_o;
  logic          gnt_i = 1'b1;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic [31:0]   rdata_i;
  logic          lock_o;
  logic [15:0]   sec_cnt_o;
  logic [15:0]   ded_cnt_o;
  logic          ded_o;
  logic [AW-1:0] ded_addr_o;
  logic          pass_done_o;
  logic          busy_o;

  hamming32t26d_scrubber #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .interval_i(interval_i),
    .clr_cnt_i(clr_cnt_i), .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i), .lock_o(lock_o),
    .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o), .ded_o(ded_o),
    .ded_addr_o(ded_addr_o), .pass_done_o(pass_done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: preload from init_mem while load_i, read data one cycle later.
  logic [31:0] mem [DEPTH];
  logic [31:0] init_mem [DEPTH];
  logic        load_i = 1'b0;

  always @(posedge clk_i) begin
    if (load_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
    end else if (req_o && gnt_i && we_o) begin
      mem[addr_o] <= wdata_o;
    end
    if (req_o && gnt_i && !we_o) rdata_i <= mem[addr_o];
  end

  int            cyc = 0;
  int            n_rd = 0;
  int            n_ded = 0;
  int            n_pass = 0;
  logic [AW-1:0] wr_a [$];
  logic [31:0]   wr_d [$];
  int            rd_cyc [$];

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (!rst_i) begin
      if (req_o && gnt_i) begin
        if (we_o) begin
          wr_a.push_back(addr_o);
          wr_d.push_back(wdata_o);
        end else begin
          n_rd <= n_rd + 1;
          rd_cyc.push_back(cyc);
        end
      end
      if (ded_o) n_ded <= n_ded + 1;
      if (pass_done_o) n_pass <= n_pass + 1;
    end
  end

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_ok++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference encoder built directly from the codeword layout rules.
  function automatic logic [31:0] encode(input logic [25:0] d);
    logic [31:0] hv;
    logic [4:0]  s;
    int          k;
    hv = '0;
    s  = '0;
    k  = 25;
    for (int i = 31; i >= 1; i--) begin
      if ((i & (i - 1)) != 0) begin
        hv[i] = d[k];
        k--;
      end
    end
    for (int i = 1; i < 32; i++) if (hv[i]) s = s ^ 5'(i);
    for (int b = 0; b < 5; b++) hv[1 << b] = s[b];
    hv[0] = ^hv[31:1];
    return hv;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0; clr_cnt_i = 1'b0; gnt_i = 1'b1;
    interval_i = 16'd0; load_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    load_i = 1'b0;
    rst_i  = 1'b0;
    @(negedge clk_i);
  endtask

  // Enable, drop enable once the last word is in flight, then wait for IDLE.
  task automatic run_pass();
    bit hit;
    hit  = 1'b0;
    en_i = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      if (addr_o == AW'(DEPTH - 1) && lock_o) begin hit = 1'b1; break; end
    end
    en_i = 1'b0;
    chk("pass_reach_last", 32'(hit), 32'd1);
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!busy_o) begin hit = 1'b1; break; end
      @(negedge clk_i);
    end
    chk("pass_idle", 32'(hit), 32'd1);
    @(negedge clk_i);
  endtask

  typedef struct {
    int          addr;
    logic [31:0] word;
    int          nwr;
    logic [31:0] wdata;
    int          sec;
    int          ded;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int w0, d0, p0, r0, bad, sec_e, ded_e;
    bit hit;
    logic [AW-1:0] lded_e;
    logic [31:0] good [DEPTH];
    logic [AW-1:0] ea [$];
    logic [31:0] ed [$];

    vecs[0] = '{3, 32'h0000_0007, 1, 32'h0000_000F, 1, 0};
    vecs[1] = '{5, 32'h0000_003F, 0, 32'h0000_0000, 0, 1};
    vecs[2] = '{2, 32'h0000_000E, 1, 32'h0000_000F, 1, 0};
    vecs[3] = '{6, 32'h8000_0000, 1, 32'h0000_0000, 1, 0};
    vecs[4] = '{4, 32'h8000_0001, 0, 32'h0000_0000, 0, 1};
    vecs[5] = '{1, 32'h0000_000F, 0, 32'h0000_0000, 0, 0};
    vecs[6] = '{7, 32'h0001_0000, 1, 32'h0000_0000, 1, 0};

    // Reset values
    for (int i = 0; i < DEPTH; i++) init_mem[i] = '0;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_req",  32'(req_o), 0);
    chk("rst_we",   32'(we_o), 0);
    chk("rst_addr", 32'(addr_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_lock", 32'(lock_o), 0);
    chk("rst_cnts", {sec_cnt_o, ded_cnt_o}, 0);
    chk("rst_ded",  32'({ded_o, ded_addr_o, pass_done_o, busy_o}), 0);

    // All-clean memory, enable for 24 cycles
    do_reset();
    w0 = wr_a.size(); p0 = n_pass; r0 = n_rd; d0 = rd_cyc.size();
    en_i = 1'b1;
    repeat (24) @(negedge clk_i);
    en_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("clean_reads", 32'(n_rd - r0), 8);
    chk("clean_writes", 32'(wr_a.size() - w0), 0);
    chk("clean_cnts", {sec_cnt_o, ded_cnt_o}, 0);
    chk("clean_pass", 32'(n_pass - p0), 1);
    chk("clean_addr", 32'(addr_o), 0);
    chk("clean_busy", 32'(busy_o), 0);
    if (rd_cyc.size() >= d0 + 2) chk("clean_spacing", 32'(rd_cyc[d0+1] - rd_cyc[d0]), 3);
    else chk("clean_spacing_cnt", 32'(rd_cyc.size() - d0), 8);

    // Table-driven single-word cases
    foreach (vecs[v]) begin
      for (int i = 0; i < DEPTH; i++) init_mem[i] = '0;
      init_mem[vecs[v].addr] = vecs[v].word;
      do_reset();
      w0 = wr_a.size(); d0 = n_ded; p0 = n_pass;
      run_pass();
      chk($sformatf("v%0d_nwr", v), 32'(wr_a.size() - w0), 32'(vecs[v].nwr));
      if (vecs[v].nwr == 1 && wr_a.size() > w0) begin
        chk($sformatf("v%0d_waddr", v), 32'(wr_a[w0]), 32'(vecs[v].addr));
        chk($sformatf("v%0d_wdata", v), wr_d[w0], vecs[v].wdata);
      end
      chk($sformatf("v%0d_sec", v), 32'(sec_cnt_o), 32'(vecs[v].sec));
      chk($sformatf("v%0d_ded", v), 32'(ded_cnt_o), 32'(vecs[v].ded));
      chk($sformatf("v%0d_dedpulse", v), 32'(n_ded - d0), 32'(vecs[v].ded));
      chk($sformatf("v%0d_dedaddr", v), 32'(ded_addr_o),
          vecs[v].ded != 0 ? 32'(vecs[v].addr) : 32'd0);
      chk($sformatf("v%0d_pass", v), 32'(n_pass - p0), 1);
      chk($sformatf("v%0d_mem", v), mem[vecs[v].addr],
          vecs[v].nwr != 0 ? vecs[v].wdata : vecs[v].word);
    end

    // Write-back stalled by the arbiter with enable dropped during the stall
    for (int i = 0; i < DEPTH; i++) init_mem[i] = '0;
    init_mem[1] = 32'h0000_0007;
    do_reset();
    w0 = wr_a.size();
    en_i = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_i);
      if (req_o && we_o) begin hit = 1'b1; break; end
    end
    chk("stall_reach_wr", 32'(hit), 1);
    gnt_i = 1'b0;
    en_i  = 1'b0;
    chk("stall_addr", 32'(addr_o), 1);
    chk("stall_wdata", wdata_o, 32'h0000_000F);
    bad = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (!(req_o && we_o && lock_o && addr_o == AW'(1) && wdata_o == 32'h0000_000F)) bad++;
    end
    chk("stall_stable", 32'(bad), 0);
    chk("stall_no_early_wr", 32'(wr_a.size() - w0), 0);
    gnt_i = 1'b1;
    @(negedge clk_i);
    chk("stall_wr_done", 32'(wr_a.size() - w0), 1);
    chk("stall_idle", 32'({busy_o, lock_o, req_o}), 0);
    chk("stall_addr_next", 32'(addr_o), 2);
    chk("stall_mem", mem[1], 32'h0000_000F);

    // Saturation of the corrected-error counter
    for (int i = 0; i < DEPTH; i++) init_mem[i] = '0;
    init_mem[3] = 32'h0000_0007;
    do_reset();
    force dut.sec_cnt_q = 16'hFFFF;
    @(negedge clk_i);
    release dut.sec_cnt_q;
    @(negedge clk_i);
    chk("sat_preload", 32'(sec_cnt_o), 32'h0000_FFFF);
    w0 = wr_a.size();
    run_pass();
    chk("sat_hold", 32'(sec_cnt_o), 32'h0000_FFFF);
    chk("sat_wr", 32'(wr_a.size() - w0), 1);

    // Clear in the same cycle as an increment, then clear while idle
    for (int i = 0; i < DEPTH; i++) init_mem[i] = '0;
    init_mem[3] = 32'h0000_0007;
    init_mem[5] = 32'h0000_003F;
    do_reset();
    en_i = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      if (req_o && !we_o && addr_o == AW'(3)) begin hit = 1'b1; break; end
    end
    chk("clr_reach_rd3", 32'(hit), 1);
    @(negedge clk_i);
    @(negedge clk_i);
    clr_cnt_i = 1'b1;
    @(negedge clk_i);
    clr_cnt_i = 1'b0;
    chk("clr_in_wr", 32'(req_o && we_o), 1);
    chk("clr_wins", 32'(sec_cnt_o), 0);
    run_pass();
    chk("clr_after_sec", 32'(sec_cnt_o), 0);
    chk("clr_after_ded", 32'(ded_cnt_o), 1);
    clr_cnt_i = 1'b1;
    @(negedge clk_i);
    clr_cnt_i = 1'b0;
    chk("clr_idle", 32'(ded_cnt_o), 0);

    // Reset asserted while reading word 3
    for (int i = 0; i < DEPTH; i++) init_mem[i] = '0;
    init_mem[1] = 32'h0000_0007;
    init_mem[2] = 32'h0000_003F;
    do_reset();
    en_i = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      if (addr_o == AW'(3) && lock_o) begin hit = 1'b1; break; end
    end
    chk("mid_reach", 32'(hit), 1);
    chk("mid_pre_cnts", {sec_cnt_o, ded_cnt_o}, 32'h0001_0001);
    chk("mid_pre_dedaddr", 32'(ded_addr_o), 2);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_ctl", 32'({req_o, we_o, lock_o, busy_o, ded_o, pass_done_o}), 0);
    chk("mid_rst_addr", 32'({addr_o, ded_addr_o}), 0);
    chk("mid_rst_wdata", wdata_o, 0);
    chk("mid_rst_cnts", {sec_cnt_o, ded_cnt_o}, 0);
    @(negedge clk_i);
    en_i  = 1'b0;
    rst_i = 1'b0;

    // Idle interval between consecutive reads
    for (int i = 0; i < DEPTH; i++) init_mem[i] = '0;
    do_reset();
    interval_i = 16'd4;
    r0 = rd_cyc.size();
    run_pass();
    chk("intv_reads", 32'(rd_cyc.size() - r0), 8);
    if (rd_cyc.size() >= r0 + 3) begin
      chk("intv_gap01", 32'(rd_cyc[r0+1] - rd_cyc[r0]), 7);
      chk("intv_gap12", 32'(rd_cyc[r0+2] - rd_cyc[r0+1]), 7);
    end
    interval_i = 16'd0;

    // Randomized passes against the encoder-based reference
    for (int it = 0; it < 8; it++) begin
      int p1, p2, kind;
      ea.delete(); ed.delete();
      sec_e = 0; ded_e = 0; lded_e = '0;
      for (int a = 0; a < DEPTH; a++) begin
        good[a] = encode(26'($urandom));
        init_mem[a] = good[a];
        kind = $urandom_range(0, 2);
        p1 = $urandom_range(0, 31);
        p2 = (p1 + $urandom_range(1, 31)) % 32;
        if (kind >= 1) init_mem[a][p1] = ~init_mem[a][p1];
        if (kind == 2) init_mem[a][p2] = ~init_mem[a][p2];
        if (kind == 1) begin
          sec_e++; ea.push_back(AW'(a)); ed.push_back(good[a]);
        end else if (kind == 2) begin
          ded_e++; lded_e = AW'(a);
        end
      end
      do_reset();
      interval_i = 16'($urandom_range(0, 2));
      w0 = wr_a.size(); d0 = n_ded;
      run_pass();
      chk($sformatf("r%0d_nwr", it), 32'(wr_a.size() - w0), 32'(ea.size()));
      for (int j = 0; j < ea.size(); j++) begin
        if (w0 + j < wr_a.size()) begin
          chk($sformatf("r%0d_wa%0d", it, j), 32'(wr_a[w0+j]), 32'(ea[j]));
          chk($sformatf("r%0d_wd%0d", it, j), wr_d[w0+j], ed[j]);
        end
      end
      chk($sformatf("r%0d_sec", it), 32'(sec_cnt_o), 32'(sec_e));
      chk($sformatf("r%0d_ded", it), 32'(ded_cnt_o), 32'(ded_e));
      chk($sformatf("r%0d_dedpulse", it), 32'(n_ded - d0), 32'(ded_e));
      chk($sformatf("r%0d_dedaddr", it), 32'(ded_addr_o), 32'(lded_e));
      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
        if (mem[a] !== ((init_mem[a] ^ good[a]) != 0 && $countones(init_mem[a] ^ good[a]) == 1
                        ? good[a] : init_mem[a])) bad++;
      end
      chk($sformatf("r%0d_mem", it), 32'(bad), 0);
      interval_i = 16'd0;
    end

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
